// File: rtl/alu_acc_seq_if.sv
// Request/result bundle between the operand sequencer and the accumulating ALU.
// Latency: none, this file only groups the wires.
// Backpressure: in_ready from the ALU side; results are never stalled.
// Ports (slave = ALU side):
//   in_valid/in_ready/input1/input2/opcode  op request handshake
//   out_valid/out/rem/flags/has_last_res    result pulse and held result
interface alu_acc_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic [3:0]   opcode;
  logic         out_valid;
  logic [W-1:0] out;
  logic [W-1:0] rem;
  logic [4:0]   flags;
  logic         has_last_res;

  modport master (
    output in_valid, input1, input2, opcode,
    input  in_ready, out_valid, out, rem, flags, has_last_res
  );

  modport slave (
    input  in_valid, input1, input2, opcode,
    output in_ready, out_valid, out, rem, flags, has_last_res
  );
endinterface

// File: rtl/alu_acc_seq.sv
// Accumulating ALU: chained ops on a running result, iterative shift-add MULT and restoring DIV.
// Latency: 1 cycle for single-cycle ops and DIV-by-zero, W+1 cycles for MULT/DIV.
// Backpressure: in_ready low while a MULT/DIV iterates; results are a one-cycle pulse, never stalled.
// Ports: clk, clear_n (async active-low), bus (alu_acc_seq_if.slave) carrying the request
//   handshake, operands, opcode, and the out/rem/flags/has_last_res result with out_valid.
//   flags = {err, dz, ovf, carry, zero}. CNT_W must satisfy 2**CNT_W > W.
module alu_acc_seq #(
  parameter int W     = 16,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           clear_n,
  alu_acc_seq_if.slave   bus
);

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MULT  = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_RESET = 4'hF;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       acc_q, acc_d;
  logic               has_q, has_d;
  // Iteration registers: MULT keeps the 2W partial product in {hi,lo};
  // DIV keeps the partial remainder in hi and shifts dividend->quotient through lo.
  logic [W-1:0]       hi_q, hi_d;
  logic [W-1:0]       lo_q, lo_d;
  logic [W-1:0]       opnd_q, opnd_d;   // multiplicand or divisor
  logic               is_div_q, is_div_d;
  logic [W-1:0]       out_q, out_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [4:0]         flags_q, flags_d;
  logic               ov_q, ov_d;

  logic [W-1:0]       a_sel, b_sel;
  logic               accept, is_long;

  // Once a result exists it becomes operand A and input1 slides into the B slot.
  assign a_sel   = has_q ? acc_q : bus.input1;
  assign b_sel   = has_q ? bus.input1 : bus.input2;
  assign accept  = bus.in_valid && (state_q == S_IDLE);
  // DIV by zero finishes in one cycle, so it never enters BUSY.
  assign is_long = (bus.opcode == OP_MULT) || ((bus.opcode == OP_DIV) && (b_sel != '0));

  // Single-cycle ALU
  logic [W:0]   add_w, sub_w;
  logic [W-1:0] sc_out, sc_rem;
  logic         sc_err, sc_dz, sc_ovf, sc_carry, sc_wr, sc_clr;

  always_comb begin
    add_w    = {1'b0, a_sel} + {1'b0, b_sel};
    sub_w    = {1'b0, a_sel} - {1'b0, b_sel};
    sc_out   = acc_q;
    sc_rem   = '0;
    sc_err   = 1'b0;
    sc_dz    = 1'b0;
    sc_ovf   = 1'b0;
    sc_carry = 1'b0;
    sc_wr    = 1'b0;
    sc_clr   = 1'b0;
    case (bus.opcode)
      OP_NOOP: begin
      end
      OP_ADD: begin
        sc_out   = add_w[W-1:0];
        sc_carry = add_w[W];
        sc_ovf   = (a_sel[W-1] == b_sel[W-1]) && (add_w[W-1] != a_sel[W-1]);
        sc_wr    = 1'b1;
      end
      OP_SUB: begin
        sc_out   = sub_w[W-1:0];
        sc_carry = sub_w[W];  // wraps high exactly when A < B
        sc_ovf   = (a_sel[W-1] != b_sel[W-1]) && (sub_w[W-1] != a_sel[W-1]);
        sc_wr    = 1'b1;
      end
      OP_MULT: begin
      end
      OP_DIV: begin
        // Only the divide-by-zero case is resolved here.
        sc_out = '1;
        sc_rem = a_sel;
        sc_dz  = 1'b1;
        sc_wr  = 1'b1;
      end
      OP_AND: begin
        sc_out = a_sel & b_sel;
        sc_wr  = 1'b1;
      end
      OP_OR: begin
        sc_out = a_sel | b_sel;
        sc_wr  = 1'b1;
      end
      OP_XOR: begin
        sc_out = a_sel ^ b_sel;
        sc_wr  = 1'b1;
      end
      OP_NOT: begin
        sc_out = ~a_sel;
        sc_wr  = 1'b1;
      end
      OP_RESET: begin
        sc_out = '0;
        sc_clr = 1'b1;
      end
      default: sc_err = 1'b1;
    endcase
  end

  // One MULT/DIV iteration
  logic [W:0]   mul_sum;
  logic [W:0]   div_sh;
  logic [W-1:0] div_dif;
  logic         div_ge;
  logic [W-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    div_sh  = {hi_q, lo_q[W-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    // Only used when div_ge, where the true difference is below the divisor and fits W bits.
    div_dif = div_sh[W-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_dif : div_sh[W-1:0];
      step_lo = {lo_q[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  // Next-state and result logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    has_d    = has_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    out_d    = out_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    ov_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_long) begin
            state_d  = S_BUSY;
            cnt_d    = '0;
            is_div_d = (bus.opcode == OP_DIV);
            opnd_d   = (bus.opcode == OP_DIV) ? b_sel : a_sel;
            hi_d     = '0;
            lo_d     = (bus.opcode == OP_DIV) ? a_sel : b_sel;
          end else begin
            ov_d    = 1'b1;
            out_d   = sc_out;
            rem_d   = sc_rem;
            flags_d = {sc_err, sc_dz, sc_ovf, sc_carry, (sc_out == '0)};
            if (sc_wr) begin
              acc_d = sc_out;
              has_d = 1'b1;
            end
            if (sc_clr) begin
              acc_d = '0;
              has_d = 1'b0;
            end
          end
        end
      end
      S_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          ov_d    = 1'b1;
          out_d   = step_lo;
          rem_d   = is_div_q ? step_hi : '0;
          // MULT overflow: anything left in the upper half of the full product.
          flags_d = {1'b0, 1'b0, (!is_div_q && (step_hi != '0)), 1'b0, (step_lo == '0)};
          acc_d   = step_lo;
          has_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      has_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      out_q    <= '0;
      rem_q    <= '0;
      flags_q  <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      has_q    <= has_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      out_q    <= out_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      ov_q     <= ov_d;
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.out_valid    = ov_q;
  assign bus.out          = out_q;
  assign bus.rem          = rem_q;
  assign bus.flags        = flags_q;
  assign bus.has_last_res = has_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Testbench for alu_acc_seq: directed scenarios plus randomized ops against a behavioural model.
// Latency: checks 1 cycle for single-cycle ops and W+1 for MULT/DIV.
// Backpressure: checks in_ready stays low while a MULT/DIV iterates.
module tb_alu_acc_seq;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] r;
    logic [4:0]   f;      // {err,dz,ovf,carry,zero}
    logic [7:0]   lat;    // cycles from accept to out_valid, FF = never came
    logic [7:0]   busy;   // cycles in_ready was low while waiting
    logic         h;      // has_last_res at the result cycle
    logic         pulse;  // out_valid one cycle after the result
  } res_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [W-1:0] acc_m = '0;
  bit           has_m = 1'b0;

  alu_acc_seq_if #(.W(W)) bus ();

  alu_acc_seq #(.W(W), .CNT_W(5)) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic string fmt(res_t x);
    return $sformatf("out=%h rem=%h flags=%b lat=%0d busy=%0d has=%b pulse=%b",
                     x.o, x.r, x.f, x.lat, x.busy, x.h, x.pulse);
  endfunction

  // Reference model: arithmetic straight from the opcode definitions.
  task automatic model(input logic [3:0] opc, input logic [W-1:0] in1, input logic [W-1:0] in2,
                       output res_t e);
    longint full, a, b, sa, sb, ss, r, m;
    bit wr;
    full = longint'(1) << W;
    e = '0;
    e.lat = 8'd1;
    wr = 1'b0;
    a = has_m ? longint'(acc_m) : longint'(in1);
    b = has_m ? longint'(in1) : longint'(in2);
    sa = (a >= full / 2) ? a - full : a;
    sb = (b >= full / 2) ? b - full : b;
    r = 0;
    case (opc)
      4'h0: r = longint'(acc_m);
      4'h1: begin
        r = a + b;
        e.f[1] = (r >= full);
        ss = sa + sb;
        e.f[2] = (ss > full / 2 - 1) || (ss < -(full / 2));
        r = r % full;
        wr = 1'b1;
      end
      4'h2: begin
        e.f[1] = (a < b);
        ss = sa - sb;
        e.f[2] = (ss > full / 2 - 1) || (ss < -(full / 2));
        r = (a - b + full) % full;
        wr = 1'b1;
      end
      4'h3: begin
        m = a * b;
        r = m % full;
        e.f[2] = (m >= full);
        e.lat = 8'(W + 1);
        e.busy = 8'(W);
        wr = 1'b1;
      end
      4'h4: begin
        if (b == 0) begin
          r = full - 1;
          e.r = W'(a);
          e.f[3] = 1'b1;
        end else begin
          r = a / b;
          e.r = W'(a % b);
          e.lat = 8'(W + 1);
          e.busy = 8'(W);
        end
        wr = 1'b1;
      end
      4'h5: begin r = a & b;        wr = 1'b1; end
      4'h6: begin r = a | b;        wr = 1'b1; end
      4'h7: begin r = a ^ b;        wr = 1'b1; end
      4'h8: begin r = full - 1 - a; wr = 1'b1; end
      4'hF: begin
        r = 0;
        acc_m = '0;
        has_m = 1'b0;
      end
      default: begin
        r = longint'(acc_m);
        e.f[4] = 1'b1;
      end
    endcase
    e.o = W'(r);
    e.f[0] = (e.o == '0);
    if (wr) begin
      acc_m = e.o;
      has_m = 1'b1;
    end
    e.h = has_m;
  endtask

  // Drives one op through the handshake and collects what the DUT reported. Starts and ends at negedge.
  task automatic issue(input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                       output res_t g);
    int n;
    g = '0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.opcode   = opc;
    bus.input1   = a;
    bus.input2   = b;
    @(posedge clk);
    @(negedge clk);
    // Noise on the request lines while in_valid is low must be ignored.
    bus.in_valid = 1'b0;
    bus.opcode   = 4'($urandom);
    bus.input1   = W'($urandom);
    bus.input2   = W'($urandom);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready !== 1'b1) g.busy = g.busy + 8'd1;
      @(negedge clk);
      n++;
    end
    if (bus.out_valid === 1'b1) begin
      g.lat = 8'(n);
      g.o   = bus.out;
      g.r   = bus.rem;
      g.f   = bus.flags;
      g.h   = bus.has_last_res;
    end else begin
      g.lat = 8'hFF;
    end
    @(negedge clk);
    g.pulse = bus.out_valid;
  endtask

  task automatic step(input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                      output res_t g, output res_t e);
    model(opc, a, b, e);
    issue(opc, a, b, g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    acc_m = '0;
    has_m = 1'b0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (bus.out !== '0)          begin n_fail++; $display("FAIL reset_out got %h need 0", bus.out); end
    n_tests++; if (bus.rem !== '0)          begin n_fail++; $display("FAIL reset_rem got %h need 0", bus.rem); end
    n_tests++; if (bus.flags !== 5'b0)      begin n_fail++; $display("FAIL reset_flags got %b need 0", bus.flags); end
    n_tests++; if (bus.out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b need 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b need 1", bus.in_ready); end
    n_tests++; if (bus.has_last_res !== 1'b0) begin n_fail++; $display("FAIL reset_has got %b need 0", bus.has_last_res); end
    clear_n = 1'b1;
    acc_m = '0;
    has_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    res_t g, e;
    step(4'hF, W'(0), W'(0), g, e);
    n_tests++; if (g !== e) begin n_fail++; $display("FAIL add_reset_op got %s exp %s", fmt(g), fmt(e)); end
    step(4'h1, W'(1), W'(1), g, e);
    n_tests++; if (g !== e) begin n_fail++; $display("FAIL add_1_1 got %s exp %s", fmt(g), fmt(e)); end
    n_tests++; if (g.o !== W'(2) || g.h !== 1'b1 || g.lat !== 8'd1)
      begin n_fail++; $display("FAIL add_1_1_lit got out=%h has=%b lat=%0d need 0002/1/1", g.o, g.h, g.lat); end
    step(4'h1, W'(1), W'(0), g, e);
    n_tests++; if (g.o !== W'(3) || g !== e)
      begin n_fail++; $display("FAIL add_chain got %s exp %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_sub();
    res_t g, e;
    step(4'hF, W'(0), W'(0), g, e);
    step(4'h2, W'(15), W'(1), g, e);
    n_tests++; if (g.o !== W'(14) || g !== e) begin n_fail++; $display("FAIL sub_15_1 got %s exp %s", fmt(g), fmt(e)); end
    step(4'h2, W'(1), W'(0), g, e);
    n_tests++; if (g.o !== W'(13) || g !== e) begin n_fail++; $display("FAIL sub_chain got %s exp %s", fmt(g), fmt(e)); end
    step(4'h2, W'(20), W'(0), g, e);
    n_tests++; if (g.o !== 16'hFFF9 || g.f[1] !== 1'b1 || g !== e)
      begin n_fail++; $display("FAIL sub_borrow got %s exp %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_mult();
    res_t g, e;
    step(4'hF, W'(0), W'(0), g, e);
    step(4'h3, W'(2), W'(2), g, e);
    n_tests++; if (g !== e) begin n_fail++; $display("FAIL mult_2_2 got %s exp %s", fmt(g), fmt(e)); end
    // in_ready low for the W busy cycles after the accept cycle; out_valid at accept+W+1.
    n_tests++; if (g.o !== W'(4) || g.lat !== 8'd17 || g.busy !== 8'd16)
      begin n_fail++; $display("FAIL mult_2_2_lit got out=%h lat=%0d busy=%0d need 0004/17/16", g.o, g.lat, g.busy); end
    step(4'hF, W'(0), W'(0), g, e);
    step(4'h3, 16'h0100, 16'h0100, g, e);
    n_tests++; if (g.o !== '0 || g.f !== 5'b00101 || g !== e)
      begin n_fail++; $display("FAIL mult_ovf got %s exp %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_div();
    res_t g, e;
    step(4'hF, W'(0), W'(0), g, e);
    step(4'h4, W'(100), W'(7), g, e);
    n_tests++; if (g.o !== W'(14) || g.r !== W'(2) || g.lat !== 8'd17 || g !== e)
      begin n_fail++; $display("FAIL div_100_7 got %s exp %s", fmt(g), fmt(e)); end
    step(4'h4, W'(0), W'(0), g, e);
    n_tests++; if (g.o !== 16'hFFFF || g.r !== W'(14) || g.f[3] !== 1'b1 || g.lat !== 8'd1 || g !== e)
      begin n_fail++; $display("FAIL div_by_zero got %s exp %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_abort();
    res_t g, e;
    int seen;
    step(4'hF, W'(0), W'(0), g, e);
    step(4'h1, W'(99), W'(1), g, e);
    // DIV acc(100) by 7, then reset mid-iteration.
    bus.in_valid = 1'b1;
    bus.opcode   = 4'h4;
    bus.input1   = W'(7);
    bus.input2   = W'(0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    clear_n = 1'b0;
    #1;
    n_tests++; if (bus.out !== '0 || bus.rem !== '0 || bus.flags !== 5'b0)
      begin n_fail++; $display("FAIL abort_outputs got out=%h rem=%h flags=%b need 0", bus.out, bus.rem, bus.flags); end
    n_tests++; if (bus.in_ready !== 1'b1 || bus.has_last_res !== 1'b0 || bus.out_valid !== 1'b0)
      begin n_fail++; $display("FAIL abort_ctrl got rdy=%b has=%b ov=%b need 1/0/0", bus.in_ready, bus.has_last_res, bus.out_valid); end
    @(negedge clk);
    clear_n = 1'b1;
    acc_m = '0;
    has_m = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result got %0d pulses need 0", seen); end
    step(4'h1, W'(3), W'(4), g, e);
    n_tests++; if (g.o !== W'(7) || g !== e) begin n_fail++; $display("FAIL abort_then_add got %s exp %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_logic();
    res_t g, e;
    step(4'hF, W'(0), W'(0), g, e);
    step(4'h5, 16'hFF00, 16'h7E00, g, e);
    n_tests++; if (g.o !== 16'h7E00 || g !== e) begin n_fail++; $display("FAIL and_first got %s exp %s", fmt(g), fmt(e)); end
    step(4'h5, 16'h03C0, W'(0), g, e);
    n_tests++; if (g.o !== 16'h0200 || g !== e) begin n_fail++; $display("FAIL and_chain got %s exp %s", fmt(g), fmt(e)); end
    step(4'hA, 16'h1234, 16'h5678, g, e);
    n_tests++; if (g.o !== 16'h0200 || g.f[4] !== 1'b1 || g !== e)
      begin n_fail++; $display("FAIL undef_op got %s exp %s", fmt(g), fmt(e)); end
    step(4'h0, W'(0), W'(0), g, e);
    n_tests++; if (g.o !== 16'h0200 || g !== e) begin n_fail++; $display("FAIL noop_after_undef got %s exp %s", fmt(g), fmt(e)); end
  endtask

  task automatic test_back_to_back();
    res_t e;
    logic [3:0] ops [8];
    ops = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'hF};
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = ops[i];
      bus.input1   = W'($urandom);
      bus.input2   = W'($urandom);
      model(ops[i], bus.input1, bus.input2, e);
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out !== e.o || bus.rem !== e.r || bus.flags !== e.f || bus.has_last_res !== e.h)
        begin n_fail++; $display("FAIL b2b_%0d got ov=%b out=%h rem=%h flags=%b has=%b exp out=%h rem=%h flags=%b has=%b",
          i, bus.out_valid, bus.out, bus.rem, bus.flags, bus.has_last_res, e.o, e.r, e.f, e.h); end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    res_t g, e;
    logic [3:0] opc;
    logic [W-1:0] a, b;
    for (int i = 0; i < 80; i++) begin
      opc = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = '0;
        1: a = W'($urandom_range(0, 15));
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      step(opc, a, b, g, e);
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL rand_%0d op=%h got %s exp %s", i, opc, fmt(g), fmt(e)); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.opcode   = 4'h0;
    bus.input1   = '0;
    bus.input2   = '0;
    test_reset();
    test_add();
    test_sub();
    test_mult();
    test_div();
    test_abort();
    test_logic();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, need completion before 1ms");
    $fatal(1, "watchdog");
  end
endmodule
